// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALUOp codes, ALU control words and datapath mux selects.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format depends only on the opcode, independent of FSM state.
   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/rv_alu_op_decoder.sv
// Maps the controller's ALUOp plus instruction function fields onto the
// 3-bit ALU control word.
module rv_alu_op_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type can subtract; addi with imm[10] set stays an add.
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives every datapath select/enable.
module rv_multicycle_controller
   import rv_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0,
   parameter bit         MEM_WAIT_EN = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       instr_done,
   output logic       trap
);

   state_t     state_reg, state_next;
   logic       mem_ready_eff;
   logic [1:0] alu_op;
   logic       pc_update, branch;
   logic       ir_write_raw, mem_write_raw, reg_write_raw, instr_done_raw;

   assign mem_ready_eff = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= state_t'(RESET_STATE);
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      adr_src        = 1'b0;
      result_src     = RES_ALUOUT;
      alu_src_a      = SRCA_PC;
      alu_src_b      = SRCB_RS2;
      alu_op         = ALUOP_ADD;
      pc_update      = 1'b0;
      branch         = 1'b0;
      ir_write_raw   = 1'b0;
      mem_write_raw  = 1'b0;
      reg_write_raw  = 1'b0;
      instr_done_raw = 1'b0;
      trap           = 1'b0;
      case (state_reg)
         S_FETCH: begin
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALURESULT;
            ir_write_raw = mem_ready_eff;
            pc_update    = mem_ready_eff;
            if (mem_ready_eff) state_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculative branch/jump target lands in ALUOut.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECR;
               OP_ITYPE:     state_next = S_EXECI;
               OP_BEQ:       state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
               default:      state_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready_eff) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src     = RES_DATA;
            reg_write_raw  = 1'b1;
            instr_done_raw = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src        = 1'b1;
            mem_write_raw  = 1'b1;
            instr_done_raw = mem_ready_eff;
            if (mem_ready_eff) state_next = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw  = 1'b1;
            instr_done_raw = 1'b1;
            state_next     = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a      = SRCA_RS1;
            alu_op         = ALUOP_SUB;
            branch         = 1'b1;
            instr_done_raw = 1'b1;
            state_next     = S_FETCH;
         end
         S_JAL: begin
            // PC <- target from ALUOut while the ALU forms OldPC+4 for rd.
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_update  = 1'b1;
            state_next = S_ALUWB;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: state_next = S_TRAP;
      endcase
   end

   // Enables are masked by rst so nothing is written while reset is held.
   assign pc_write   = ~rst & (pc_update | (branch & zero));
   assign ir_write   = ~rst & ir_write_raw;
   assign mem_write  = ~rst & mem_write_raw;
   assign reg_write  = ~rst & reg_write_raw;
   assign instr_done = ~rst & instr_done_raw;
   assign imm_src    = imm_sel(opcode);

   rv_alu_op_decoder u_alu_op_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op5         (opcode[5]),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

endmodule
